// File: rtl/lfsr_stream_cipher_if.sv
// Valid/ready word stream between the cipher and its neighbours.
// The producer uses the master modport; the consumer uses the slave modport.
interface lfsr_stream_cipher_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream XOR cipher with a registered valid/ready output stage.
// The same block both encrypts and decrypts; the seed can be reloaded at run time.
module lfsr_stream_cipher #(
    parameter int                DATA_W = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_stream_cipher_if.slave  i_in,
    lfsr_stream_cipher_if.master o_out,
    input  logic                 i_seed_load,
    input  logic [LFSR_W-1:0]    i_seed_in,
    output logic [CNT_W-1:0]     o_word_cnt,
    output logic                 o_busy
);

    typedef enum logic {ST_RUN, ST_LOAD} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load_en;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_word_cnt;
    logic                w_in_ready;
    logic                w_xfer_in;
    logic                w_xfer_out;
    logic [DATA_W-1:0]   w_key;
    logic [LFSR_W-1:0]   w_seed_eff;
    logic [LFSR_W-1:0]   w_lfsr_adv;

    // DATA_W Fibonacci steps in one go; an all-zero state would never leave zero, so reseed.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int k = 0; k < DATA_W; k++) begin
            v = {v[LFSR_W-2:0], ^(v & TAPS)};
        end
        if (s == '0) begin
            v = SEED;
        end
        return v;
    endfunction

    assign w_key      = r_lfsr[DATA_W-1:0];
    assign w_lfsr_adv = lfsr_advance(r_lfsr);
    assign w_seed_eff = (i_seed_in == '0) ? SEED : i_seed_in;

    assign w_in_ready = (r_state == ST_RUN) & ~i_seed_load & (~r_out_valid | o_out.ready);
    assign w_xfer_in  = i_in.valid & w_in_ready;
    assign w_xfer_out = r_out_valid & o_out.ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_seed_load) begin
                    w_state_nxt = ST_LOAD;
                    w_load_en   = 1'b1;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
                if (i_seed_load) begin
                    w_state_nxt = ST_LOAD;
                    w_load_en   = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr     <= SEED;
            r_word_cnt <= '0;
        end else if (w_load_en) begin
            r_lfsr     <= w_seed_eff;
            r_word_cnt <= '0;
        end else if (w_xfer_in) begin
            r_lfsr     <= w_lfsr_adv;
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    // A drain and an accept on the same edge keep the stage full: one word per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_in.data ^ w_key;
        end else if (w_xfer_out) begin
            r_out_valid <= 1'b0;
        end
    end

    assign i_in.ready  = w_in_ready;
    assign o_out.valid = r_out_valid;
    assign o_out.data  = r_out_data;
    assign o_word_cnt  = r_word_cnt;
    assign o_busy      = r_out_valid | (r_state == ST_LOAD);

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed bench for lfsr_stream_cipher: hand-derived keystream values plus a
// two-instance round trip of random bytes.
module tb_lfsr_stream_cipher;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        a_ready;
    logic        rt_mode;
    logic [15:0] a_cnt;
    logic        a_busy;
    logic [15:0] b_cnt;
    logic        b_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sent[$];
    logic [7:0] got[$];

    lfsr_stream_cipher_if #(.DATA_W(8)) a_in  ();
    lfsr_stream_cipher_if #(.DATA_W(8)) a_out ();
    lfsr_stream_cipher_if #(.DATA_W(8)) b_in  ();
    lfsr_stream_cipher_if #(.DATA_W(8)) b_out ();

    assign a_out.ready = rt_mode ? b_in.ready : a_ready;
    assign b_in.valid  = rt_mode & a_out.valid;
    assign b_in.data   = a_out.data;

    lfsr_stream_cipher dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_in        (a_in),
        .o_out       (a_out),
        .i_seed_load (seed_load),
        .i_seed_in   (seed_in),
        .o_word_cnt  (a_cnt),
        .o_busy      (a_busy)
    );

    lfsr_stream_cipher dut_b (
        .clk         (clk),
        .rst         (rst),
        .i_in        (b_in),
        .o_out       (b_out),
        .i_seed_load (1'b0),
        .i_seed_in   (16'h0000),
        .o_word_cnt  (b_cnt),
        .o_busy      (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rt_mode && !rst) begin
            if (a_in.valid && a_in.ready) sent.push_back(a_in.data);
            if (b_out.valid && b_out.ready) got.push_back(b_out.data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        rst         = 1'b0;
        seed_load   = 1'b0;
        seed_in     = 16'h0000;
        a_ready     = 1'b1;
        rt_mode     = 1'b0;
        a_in.valid  = 1'b0;
        a_in.data   = 8'h00;
        b_out.ready = 1'b1;

        // Reset values while rst is held
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", a_out.valid, 1'b0);
        chk("rst_out_data",  a_out.data,  8'h00);
        chk("rst_word_cnt",  a_cnt,       16'h0000);
        chk("rst_lfsr",      dut_a.r_lfsr, 16'hACE1);
        chk("rst_busy",      a_busy,      1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_in_ready", a_in.ready, 1'b1);

        // First word after reset: key 0xE1
        a_in.valid = 1'b1;
        a_in.data  = 8'h00;
        tick();
        a_in.valid = 1'b0;
        chk("t1_out_valid", a_out.valid, 1'b1);
        chk("t1_out_data",  a_out.data,  8'hE1);
        chk("t1_lfsr",      dut_a.r_lfsr, 16'hE1E4);
        chk("t1_word_cnt",  a_cnt,       16'd1);
        chk("t1_busy",      a_busy,      1'b1);
        tick();
        chk("t1_drained",   a_out.valid, 1'b0);

        // Back-to-back words from a fresh seed
        do_reset();
        a_in.valid = 1'b1;
        a_in.data  = 8'h41;
        #1 chk("t2_in_ready0", a_in.ready, 1'b1);
        tick();
        chk("t2_out_data0", a_out.data, 8'hA0);
        chk("t2_out_valid0", a_out.valid, 1'b1);
        #1 chk("t2_in_ready1", a_in.ready, 1'b1);
        tick();
        a_in.valid = 1'b0;
        chk("t2_out_data1", a_out.data, 8'hA5);
        chk("t2_word_cnt",  a_cnt,      16'd2);
        chk("t2_lfsr",      dut_a.r_lfsr, 16'hE455);
        tick();
        chk("t2_drained",   a_out.valid, 1'b0);

        // Downstream stall: output held, LFSR frozen, nothing lost
        a_ready    = 1'b0;
        a_in.valid = 1'b1;
        a_in.data  = 8'h00;
        tick();
        chk("t3_out_data",  a_out.data, 8'h55);
        a_in.data = 8'h0F;
        #1 chk("t3_in_ready_stall", a_in.ready, 1'b0);
        tick();
        tick();
        chk("t3_held_data",  a_out.data,  8'h55);
        chk("t3_held_valid", a_out.valid, 1'b1);
        chk("t3_held_lfsr",  dut_a.r_lfsr, 16'h55DD);
        chk("t3_held_cnt",   a_cnt,       16'd3);
        a_ready = 1'b1;
        #1 chk("t3_in_ready_rel", a_in.ready, 1'b1);
        tick();
        chk("t3_next_data",  a_out.data,  8'hD2);
        chk("t3_next_valid", a_out.valid, 1'b1);
        chk("t3_next_cnt",   a_cnt,       16'd4);
        a_in.valid = 1'b0;
        tick();
        chk("t3_drained",    a_out.valid, 1'b0);

        // Seed reload with the reset seed; offered word must be refused
        seed_load  = 1'b1;
        seed_in    = 16'hACE1;
        a_in.valid = 1'b1;
        a_in.data  = 8'h00;
        #1 chk("t4_ready_ldcyc", a_in.ready, 1'b0);
        tick();
        seed_load = 1'b0;
        chk("t4_cnt_clr",   a_cnt,       16'd0);
        chk("t4_lfsr",      dut_a.r_lfsr, 16'hACE1);
        chk("t4_busy",      a_busy,      1'b1);
        chk("t4_no_accept", a_out.valid, 1'b0);
        #1 chk("t4_ready_load", a_in.ready, 1'b0);
        tick();
        #1 chk("t4_ready_run", a_in.ready, 1'b1);
        tick();
        a_in.valid = 1'b0;
        chk("t4_key_again", a_out.data, 8'hE1);
        chk("t4_cnt_one",   a_cnt,      16'd1);

        // Arbitrary seed, then zero seed falls back to SEED, then re-load in LOAD
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        tick();
        seed_load = 1'b0;
        chk("t4_seed_1234", dut_a.r_lfsr, 16'h1234);
        chk("t4_cnt_clr2",  a_cnt,       16'd0);
        tick();
        a_in.valid = 1'b1;
        a_in.data  = 8'h00;
        tick();
        a_in.valid = 1'b0;
        chk("t4_key_34", a_out.data, 8'h34);
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        chk("t4_zero_seed", dut_a.r_lfsr, 16'hACE1);
        chk("t4_busy_ld",   a_busy,      1'b1);
        seed_in = 16'h00FF;
        tick();
        seed_load = 1'b0;
        chk("t4_reload", dut_a.r_lfsr, 16'h00FF);
        #1 chk("t4_ready_reload", a_in.ready, 1'b0);
        tick();
        #1 chk("t4_ready_after", a_in.ready, 1'b1);
        chk("t4_busy_idle", a_busy, 1'b0);

        // Asynchronous reset with a word pending and another offered
        a_ready    = 1'b0;
        a_in.valid = 1'b1;
        a_in.data  = 8'h12;
        tick();
        chk("t6_pending", a_out.valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("t6_out_valid", a_out.valid, 1'b0);
        chk("t6_lfsr",      dut_a.r_lfsr, 16'hACE1);
        chk("t6_word_cnt",  a_cnt,       16'd0);
        chk("t6_out_data",  a_out.data,  8'h00);
        #1 rst = 1'b0;
        a_in.valid = 1'b0;
        a_ready    = 1'b1;
        tick();

        // Round trip through a second instance with the same seed
        rt_mode = 1'b1;
        cyc     = 0;
        while ((sent.size() < 256) && (cyc < 4000)) begin
            a_in.valid  = ($urandom_range(0, 3) != 0);
            a_in.data   = 8'($urandom);
            b_out.ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        a_in.valid  = 1'b0;
        b_out.ready = 1'b1;
        while ((got.size() < 256) && (cyc < 5000)) begin
            tick();
            cyc++;
        end
        chk("rt_count", got.size(), 256);
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            chk("rt_byte", got[i], sent[i]);
        end
        chk("rt_cnt_a", a_cnt, 16'd256);
        chk("rt_cnt_b", b_cnt, 16'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
